// File: rtl/button_debounce_n.sv
// button_debounce_n: multi-channel button synchroniser, debouncer and press/release/repeat pulse generator
module button_debounce_n #(
   parameter int CHANNELS        = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_raw,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_press,
   output logic [CHANNELS-1:0] btn_release
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
   localparam logic [CHANNELS-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [CHANNELS-1:0] s1_q, s2_q, p;
   logic [CHANNELS-1:0] level_q, level_d, press_q, press_d, release_q, release_d, rep_q, rep_d;
   logic [CW-1:0]       cnt_q  [CHANNELS];
   logic [CW-1:0]       cnt_d  [CHANNELS];
   logic [RW-1:0]       rcnt_q [CHANNELS];
   logic [RW-1:0]       rcnt_d [CHANNELS];

   assign p           = s2_q ^ IDLE;
   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

   // Per channel: debounce count, level update, edge pulses and hold-to-repeat timing
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         level_d[i] = level_q[i];
         cnt_d[i]   = '0;
         rcnt_d[i]  = '0;
         rep_d[i]   = 1'b0;
         if (p[i] != level_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) level_d[i] = p[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
         press_d[i]   = ~level_q[i] & level_d[i];
         release_d[i] = level_q[i] & ~level_d[i];
         if (REPEAT_EN != 0 && level_q[i] && level_d[i]) begin
            if (rcnt_q[i] == (rep_q[i] ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
               press_d[i] = 1'b1;
               rep_d[i]   = 1'b1;
            end else begin
               rcnt_d[i] = rcnt_q[i] + 1'b1;
               rep_d[i]  = rep_q[i];
            end
         end
      end
   end

   // State registers; synchroniser restarts from the released pin value on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= IDLE;
         s2_q      <= IDLE;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         rep_q     <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= '0;
            rcnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= btn_raw;
         s2_q      <= s1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         rep_q     <= rep_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= cnt_d[i];
            rcnt_q[i] <= rcnt_d[i];
         end
      end
   end
endmodule

// File: tb/tb_button_debounce_n.sv
// tb_button_debounce_n: directed checks of debounce latency, bounce rejection, pulses, repeat and reset
module tb_button_debounce_n;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] btn_raw = 2'b11;
   logic [1:0] level0, press0, rel0, level1, press1, rel1;
   int checks = 0, failures = 0;

   button_debounce_n dut0 (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(level0), .btn_press(press0), .btn_release(rel0)
   );

   button_debounce_n #(.REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut1 (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(level1), .btn_press(press1), .btn_release(rel1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n cycles on dut0; pulses pm/rm expected only at cycle 'at', level lb before and la from 'at' on
   task automatic run(input string ph, input int n, input int at, input logic [1:0] pm,
                      input logic [1:0] rm, input logic [1:0] lb, input logic [1:0] la);
      for (int k = 1; k <= n; k++) begin
         tick();
         chk($sformatf("%s.press.%0d", ph, k), {6'b0, press0}, {6'b0, (k == at) ? pm : 2'b00});
         chk($sformatf("%s.rel.%0d", ph, k), {6'b0, rel0}, {6'b0, (k == at) ? rm : 2'b00});
         chk($sformatf("%s.lvl.%0d", ph, k), {6'b0, level0}, {6'b0, (at != 0 && k >= at) ? la : lb});
      end
   endtask

   initial begin
      run("reset", 3, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      run("idle", 3, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      btn_raw = 2'b10;
      run("press0", 20, 6, 2'b01, 2'b00, 2'b00, 2'b01);
      btn_raw = 2'b00;
      run("glitch1", 3, 0, 2'b00, 2'b00, 2'b01, 2'b01);
      btn_raw = 2'b10;
      run("glitch1_after", 8, 0, 2'b00, 2'b00, 2'b01, 2'b01);
      btn_raw = 2'b11;
      run("release0", 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);
      for (int j = 0; j < 12; j++) begin
         btn_raw = {1'b1, ((j / 2) % 2) == 1};
         run("bounce", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      btn_raw = 2'b10;
      run("settle0", 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);
      btn_raw = 2'b11;
      run("release0b", 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);
      btn_raw = 2'b00;
      run("press_both", 12, 6, 2'b11, 2'b00, 2'b00, 2'b11);
      btn_raw = 2'b11;
      run("release_both", 8, 6, 2'b00, 2'b11, 2'b11, 2'b00);
      // auto-repeat on dut1: press at cycle 6 (T), repeats at T+8 then every 4
      btn_raw = 2'b10;
      for (int k = 1; k <= 36; k++) begin
         tick();
         chk($sformatf("rep.press.%0d", k), {6'b0, press1},
             {7'b0, (k == 6) || (k >= 14 && (k - 14) % 4 == 0)});
      end
      btn_raw = 2'b11;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("rep_rel.press.%0d", k), {6'b0, press1},
             {7'b0, (k < 6) && ((36 + k - 14) % 4 == 0)});
         chk($sformatf("rep_rel.rel.%0d", k), {6'b0, rel1}, {7'b0, k == 6});
      end
      // reset mid-count: counter at 2 after four edges, then one reset cycle
      btn_raw = 2'b10;
      run("midcount", 4, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b1;
      run("midcount_rst", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      run("midcount_after", 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);
      rst = 1'b1;
      run("held_rst", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      run("held_after", 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/button_debounce_n.md
Name: button_debounce_n

Overview:
- Parametrised multi-channel push-button conditioner for the board front end of the CPU datapath.
- Takes raw asynchronous button pins and produces per-channel outputs:
  - synchronised, debounced levels
  - single-cycle press and release pulses
  - optional hold-to-repeat press pulses
- Replaces ad-hoc single-button edge logic.
- The datapath consumes btn_press as its step/advance strobes.

Parameters:
- CHANNELS, 2, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced level changes (>=1; board builds use 500000).
- ACTIVE_LOW, 1, 1 = pin low means pressed; 0 = pin high means pressed.
- REPEAT_EN, 0, 1 = enable auto-repeat press pulses while held.
- REPEAT_DELAY, 8, cycles from debounced press to first repeat pulse (>=1).
- REPEAT_RATE, 4, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  CHANNELS  raw asynchronous button pins.
- btn_level  output  CHANNELS  debounced state, 1 = pressed, regardless of ACTIVE_LOW.
- btn_press  output  CHANNELS  one-cycle pulse on debounced press, and on each repeat.
- btn_release  output  CHANNELS  one-cycle pulse on debounced release.

Behaviour:
- Reset and clocking:
  - One clock domain. Reset is synchronous and active-high.
  - On reset: btn_level, btn_press and btn_release = 0; all counters = 0.
  - On reset, synchroniser flops load the released pin value (1 if ACTIVE_LOW, else 0).
- Synchroniser:
  - Per channel, a 2-flop synchroniser (s1, s2) on btn_raw.
  - Polarity is normalised after s2: p = s2 XOR ACTIVE_LOW.
- Debounce counter, per channel, counting to DEBOUNCE_CYCLES (width $clog2(DEBOUNCE_CYCLES+1)):
  - p == btn_level: counter := 0.
  - p != btn_level and counter < DEBOUNCE_CYCLES-1: counter += 1.
  - p != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level := p, counter := 0.
- Latency:
  - Raw pin changes and stays stable before edge 0.
  - btn_level changes after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges.
  - Any excursion shorter than DEBOUNCE_CYCLES cycles at p produces no output change; the counter restarts from 0 on every bounce.
- Press/release pulses:
  - Registered and coincident with the level transition: btn_press is high in the same cycle btn_level first reads 1.
  - btn_release is high in the first cycle btn_level reads 0.
  - Each pulse is exactly 1 cycle wide.
- Auto-repeat (REPEAT_EN=1), per-channel repeat counter:
  - Counter is cleared whenever btn_level == 0 and on the press transition.
  - While btn_level == 1 the counter increments each cycle.
  - At REPEAT_DELAY cycles after the press pulse, btn_press pulses and the counter reloads for period REPEAT_RATE.
  - Further pulses occur every REPEAT_RATE cycles until release.
  - No repeat pulse in the release cycle.
  - REPEAT_EN=0: the repeat logic is absent and btn_press is press-edge only.
- Channels:
  - Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
  - Bit i of every bus belongs to channel i.
- Reset mid-operation:
  - Any in-progress count or held level is discarded and outputs go to 0 the following cycle.
  - A button held through reset produces a fresh press pulse DEBOUNCE_CYCLES+2 edges after rst falls (the synchroniser restarts from the released value).
- Outputs are registered; there is no combinational path from btn_raw.

Test Plan:
- Reset: CHANNELS=2, ACTIVE_LOW=1, btn_raw=2'b11, rst=1 for 3 cycles -> btn_level=btn_press=btn_release=2'b00 throughout and after.
- Clean press: btn_raw[0] 1->0 before edge 0, held 20 cycles, DEBOUNCE_CYCLES=4 -> btn_level[0]=1 after edge 5 (6 edges); btn_press[0]=1 for exactly that one cycle; channel 1 outputs stay 0.
- Glitch/bounce:
  - btn_raw[1] low for 3 cycles -> no change on channel 1.
  - btn_raw[0] toggling every 2 cycles for 12 cycles, then settling low -> exactly one btn_press[0], 6 edges after the final settle.
- Release and simultaneity:
  - Both buttons released on the same cycle after being held -> btn_release=2'b11 for one cycle, 6 edges later; btn_level=2'b00.
  - Both buttons pressed together -> btn_press=2'b11 in the same cycle.
- Auto-repeat: REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_RATE=4, hold ch0 for 30 cycles after debounce -> btn_press[0] pulses at cycles T, T+8, T+12, T+16, T+20, T+24, T+28; release -> pulses stop, one btn_release[0].
- Reset mid-count: ch0 pressed, rst asserted at count 2 for 1 cycle while still held -> outputs 0 during reset; btn_press[0] 6 edges after rst deasserts.
